// File: rtl/lcd_brightness_ctrl_pkg.sv
// Shared definitions for the LCD brightness controller: level range,
// index-to-LightScale code mapping and ramp FSM state encoding.
package lcd_brightness_ctrl_pkg;

  localparam int unsigned LEVEL_MAX = 10;
  localparam int unsigned LEVEL_W   = 4;

  typedef logic [LEVEL_W-1:0] level_t;

  typedef enum logic {
    HOLD = 1'b0,
    RAMP = 1'b1
  } ramp_state_t;

  // Index 0 means backlight off (code 1); any other index k maps to 10*k.
  function automatic logic [7:0] level_to_code(input level_t idx);
    logic [7:0] code;
    if (idx == '0) begin
      code = 8'd1;
    end else begin
      code = {4'd0, idx} * 8'd10;
    end
    return code;
  endfunction

endpackage

// File: rtl/lcd_brightness_ctrl_debounce.sv
// Key conditioner: 2-FF synchroniser, stability counter and a one-cycle
// press pulse on the accepted high-to-low transition of an active-low key.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n_i,
  output logic press_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       sync_q;
  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;

  // Synchronise, then accept a new level only after it has differed from the
  // accepted level for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      press_q <= 1'b0;
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        stable_q <= sync_q[1];
        cnt_q    <= '0;
        press_q  <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/lcd_brightness_ctrl.sv
// LCD backlight brightness controller: debounced keys and host set command
// drive a saturating target index; a ramp FSM walks the current index toward
// it one notch per RAMP_CYCLES and LightScale is registered from it.
// Optional idle auto-dim is enabled by defining IDLE_DIM_EN.
module lcd_brightness_ctrl
  import lcd_brightness_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned RAMP_CYCLES     = 5000,
  parameter int unsigned DEFAULT_IDX     = 5
`ifdef IDLE_DIM_EN
  ,
  parameter logic [23:0] IDLE_CYCLES     = 24'd12_000_000
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_up_n,
  input  logic       key_dn_n,
  input  logic       set_valid,
  input  logic [3:0] set_idx,
  output logic [7:0] LightScale,
  output logic       busy,
  output logic       dimmed
);

  localparam level_t LVL_MAX = level_t'(LEVEL_MAX);
  localparam level_t LVL_ONE = level_t'(1);
  localparam level_t DEF_LVL = level_t'(DEFAULT_IDX);

  localparam int unsigned RCNT_W = (RAMP_CYCLES < 2) ? 1 : $clog2(RAMP_CYCLES + 1);
  localparam logic [RCNT_W-1:0] RCNT_MAX = RCNT_W'(RAMP_CYCLES - 1);
  localparam logic [RCNT_W-1:0] RCNT_ONE = RCNT_W'(1);

  logic              up_ev;
  logic              dn_ev;
  level_t            set_lvl;
  level_t            tgt_q, tgt_d;
  level_t            cur_q;
  ramp_state_t       state_q;
  logic [RCNT_W-1:0] ramp_cnt_q;
  logic [7:0]        code_q;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_up (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n_i (key_up_n),
    .press_o (up_ev)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_dn (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n_i (key_dn_n),
    .press_o (dn_ev)
  );

  assign set_lvl = (set_idx > LVL_MAX) ? LVL_MAX : set_idx;

`ifdef IDLE_DIM_EN
  logic        dimmed_q, dimmed_d;
  level_t      rest_q, rest_d;
  logic [23:0] idle_cnt_q;
  logic        idle_hit;

  assign idle_hit = (idle_cnt_q == IDLE_CYCLES) && !dimmed_q && (tgt_q > LVL_ONE);

  // Idle counter: cleared by any user activity, saturates at IDLE_CYCLES.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt_q <= '0;
    end else if (set_valid || up_ev || dn_ev) begin
      idle_cnt_q <= '0;
    end else if (idle_cnt_q != IDLE_CYCLES) begin
      idle_cnt_q <= idle_cnt_q + 24'd1;
    end
  end
`endif

  // Target update; while dimmed, the first key event only restores the saved level.
  always_comb begin
    tgt_d = tgt_q;
`ifdef IDLE_DIM_EN
    dimmed_d = dimmed_q;
    rest_d   = rest_q;
`endif
    if (set_valid) begin
      tgt_d = set_lvl;
`ifdef IDLE_DIM_EN
      dimmed_d = 1'b0;
    end else if (dimmed_q && (up_ev || dn_ev)) begin
      tgt_d    = rest_q;
      dimmed_d = 1'b0;
`endif
    end else if (up_ev && dn_ev) begin
      tgt_d = tgt_q;
    end else if (up_ev) begin
      if (tgt_q != LVL_MAX) tgt_d = tgt_q + LVL_ONE;
    end else if (dn_ev) begin
      if (tgt_q != '0) tgt_d = tgt_q - LVL_ONE;
`ifdef IDLE_DIM_EN
    end else if (idle_hit) begin
      rest_d   = tgt_q;
      tgt_d    = LVL_ONE;
      dimmed_d = 1'b1;
`endif
    end
  end

  // Target and auto-dim state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tgt_q <= DEF_LVL;
`ifdef IDLE_DIM_EN
      dimmed_q <= 1'b0;
      rest_q   <= DEF_LVL;
`endif
    end else begin
      tgt_q <= tgt_d;
`ifdef IDLE_DIM_EN
      dimmed_q <= dimmed_d;
      rest_q   <= rest_d;
`endif
    end
  end

  // Ramp FSM: step cur one notch toward the latest target every RAMP_CYCLES.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= HOLD;
      cur_q      <= DEF_LVL;
      ramp_cnt_q <= '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cur_q != tgt_q) begin
            state_q    <= RAMP;
            ramp_cnt_q <= '0;
          end
        end
        RAMP: begin
          if (cur_q == tgt_q) begin
            state_q <= HOLD;
          end else if (ramp_cnt_q == RCNT_MAX) begin
            ramp_cnt_q <= '0;
            cur_q      <= (tgt_q > cur_q) ? cur_q + LVL_ONE : cur_q - LVL_ONE;
          end else begin
            ramp_cnt_q <= ramp_cnt_q + RCNT_ONE;
          end
        end
        default: state_q <= HOLD;
      endcase
    end
  end

  // Output code register, one cycle behind cur_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      code_q <= level_to_code(DEF_LVL);
    end else begin
      code_q <= level_to_code(cur_q);
    end
  end

  assign LightScale = code_q;
  assign busy       = (cur_q != tgt_q);
`ifdef IDLE_DIM_EN
  assign dimmed     = dimmed_q;
`else
  assign dimmed     = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_brightness_ctrl.sv
// Self-checking bench for lcd_brightness_ctrl (DEBOUNCE=4, RAMP=3, DEFAULT_IDX=5).
// Build with IDLE_DIM_EN defined to exercise the auto-dim sequence instead of the vector table.
module tb_lcd_brightness_ctrl;

  localparam int RAMP = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_up_n = 1'b1;
  logic       key_dn_n = 1'b1;
  logic       set_valid = 1'b0;
  logic [3:0] set_idx = 4'd0;
  logic [7:0] LightScale;
  logic       busy;
  logic       dimmed;

  lcd_brightness_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .RAMP_CYCLES     (3),
    .DEFAULT_IDX     (5)
`ifdef IDLE_DIM_EN
    ,
    .IDLE_CYCLES     (24'd50)
`endif
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_up_n   (key_up_n),
    .key_dn_n   (key_dn_n),
    .set_valid  (set_valid),
    .set_idx    (set_idx),
    .LightScale (LightScale),
    .busy       (busy),
    .dimmed     (dimmed)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int illegal_cnt = 0;
  int cyc = 0;
  int last_chg = 0;
  bit mon_en = 1'b0;
  bit gap_chk = 1'b0;
  bit have_prev = 1'b0;
  logic [7:0] prev_ls;
  int sb[$];
  int m_cur = 5;

  function automatic int code_of(input int k);
    return (k == 0) ? 1 : 10 * k;
  endfunction

  function automatic bit legal(input int v);
    return (v == 1) || ((v % 10 == 0) && v >= 10 && v <= 100);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every LightScale change must match the next expected code.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!legal(int'(LightScale))) illegal_cnt++;
      if (LightScale != prev_ls) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got=%0d required=no_change", LightScale);
        end else begin
          int e;
          e = sb.pop_front();
          if (int'(LightScale) != e) begin
            errors++;
            $display("FAIL sb_code got=%0d required=%0d", LightScale, e);
          end
        end
        if (gap_chk) begin
          if (have_prev) begin
            checks++;
            if (cyc - last_chg != RAMP) begin
              errors++;
              $display("FAIL notch_gap got=%0d required=%0d", cyc - last_chg, RAMP);
            end
          end
          have_prev = 1'b1;
        end
        last_chg = cyc;
        prev_ls  = LightScale;
      end
    end
  end

  task automatic chk(input string name, input int idx, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%0d required=%0d", name, idx, got, exp);
    end
  endtask

  task automatic push_ramp(input int from, input int to);
    int k;
    k = from;
    while (k != to) begin
      k = (to > k) ? k + 1 : k - 1;
      sb.push_back(code_of(k));
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
    m_cur = 5;
    @(posedge clk);
    #1;
    chk("reset_code", 0, int'(LightScale), 50);
    chk("reset_busy", 0, int'(busy), 0);
    chk("reset_dimmed", 0, int'(dimmed), 0);
    prev_ls = LightScale;
    mon_en = 1'b1;
  endtask

  task automatic press(input bit up, input bit dn, input int hold);
    @(negedge clk);
    key_up_n = ~up;
    key_dn_n = ~dn;
    repeat (hold) @(negedge clk);
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_set(input int idx);
    @(negedge clk);
    set_valid = 1'b1;
    set_idx   = 4'(idx);
    @(negedge clk);
    set_valid = 1'b0;
  endtask

  // Up key held; set_valid lands in the same cycle as the debounced up event
  // (2 sync stages + 4 debounce cycles, event visible at the 7th edge).
  task automatic set_with_up(input int idx);
    @(negedge clk);
    key_up_n = 1'b0;
    repeat (6) @(negedge clk);
    set_valid = 1'b1;
    set_idx   = 4'(idx);
    @(negedge clk);
    set_valid = 1'b0;
    repeat (3) @(negedge clk);
    key_up_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic settle(input string name, input int idx);
    bit done;
    done = 1'b0;
    repeat (2) @(negedge clk);
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      #1;
      if (!busy && sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout[%0d] got=busy%0d_pending%0d required=settled", name, idx, busy, sb.size());
      sb.delete();
    end
    repeat (RAMP + 2) @(negedge clk);
  endtask

`ifndef IDLE_DIM_EN
  typedef enum int {OP_UP, OP_DN, OP_BOTH, OP_GLITCH, OP_SET, OP_SETUP} op_e;
  typedef struct {
    op_e op;
    int  arg;
    int  exp_code;
    bit  gap;
  } vec_t;
  localparam int NV = 14;
  vec_t vecs[NV];
`endif

  initial begin
`ifndef IDLE_DIM_EN
    vecs[0]  = '{OP_UP,     0,  60, 1'b0};
    vecs[1]  = '{OP_UP,     0,  70, 1'b0};
    vecs[2]  = '{OP_UP,     0,  80, 1'b0};
    vecs[3]  = '{OP_GLITCH, 0,  80, 1'b0};
    vecs[4]  = '{OP_UP,     0,  90, 1'b0};
    vecs[5]  = '{OP_UP,     0, 100, 1'b0};
    vecs[6]  = '{OP_UP,     0, 100, 1'b0};
    vecs[7]  = '{OP_SET,    0,   1, 1'b0};
    vecs[8]  = '{OP_DN,     0,   1, 1'b0};
    vecs[9]  = '{OP_BOTH,   0,   1, 1'b0};
    vecs[10] = '{OP_SET,    2,  20, 1'b0};
    vecs[11] = '{OP_SET,   15, 100, 1'b1};
    vecs[12] = '{OP_SETUP,  3,  30, 1'b0};
    vecs[13] = '{OP_SET,    5,  50, 1'b0};
`endif

    do_reset();

`ifndef IDLE_DIM_EN
    for (int i = 0; i < NV; i++) begin
      int nt;
      case (vecs[i].op)
        OP_UP:    nt = (m_cur < 10) ? m_cur + 1 : 10;
        OP_DN:    nt = (m_cur > 0) ? m_cur - 1 : 0;
        OP_SET,
        OP_SETUP: nt = (vecs[i].arg > 10) ? 10 : vecs[i].arg;
        default:  nt = m_cur;
      endcase
      push_ramp(m_cur, nt);
      m_cur     = nt;
      have_prev = 1'b0;
      gap_chk   = vecs[i].gap;
      case (vecs[i].op)
        OP_UP:     press(1'b1, 1'b0, 10);
        OP_DN:     press(1'b0, 1'b1, 10);
        OP_BOTH:   press(1'b1, 1'b1, 10);
        OP_GLITCH: press(1'b1, 1'b0, 2);
        OP_SET:    do_set(vecs[i].arg);
        default:   set_with_up(vecs[i].arg);
      endcase
      settle("vec", i);
      gap_chk = 1'b0;
      chk("vec_code", i, int'(LightScale), vecs[i].exp_code);
      chk("vec_busy", i, int'(busy), 0);
    end

    // Reversal mid-ramp: at 70 heading to 90, retarget to 6.
    begin
      bit seen;
      seen = 1'b0;
      sb.push_back(60);
      sb.push_back(70);
      do_set(9);
      for (int t = 0; t < 100; t++) begin
        @(negedge clk);
        if (LightScale == 8'd70) begin
          seen = 1'b1;
          break;
        end
      end
      chk("rev_reach70", 0, int'(seen), 1);
      set_valid = 1'b1;
      set_idx   = 4'd6;
      sb.push_back(60);
      @(negedge clk);
      set_valid = 1'b0;
      settle("rev", 0);
      repeat (10) @(negedge clk);
      chk("rev_code", 0, int'(LightScale), 60);
      chk("rev_busy", 0, int'(busy), 0);
      chk("rev_dimmed", 0, int'(dimmed), 0);
    end
`else
    // Auto-dim: reach 80, idle into dim, key restore, idle again, reset mid-dim.
    begin
      bit seen;
      push_ramp(5, 8);
      do_set(8);
      settle("idle_up", 0);
      chk("idle_code80", 0, int'(LightScale), 80);
      seen = 1'b0;
      for (int t = 0; t < 120; t++) begin
        @(negedge clk);
        if (dimmed) begin
          seen = 1'b1;
          break;
        end
      end
      chk("idle_dimmed", 0, int'(seen), 1);
      push_ramp(8, 1);
      settle("idle_dim", 0);
      chk("idle_code10", 0, int'(LightScale), 10);
      chk("idle_dimmed_hold", 0, int'(dimmed), 1);
      push_ramp(1, 8);
      press(1'b1, 1'b0, 10);
      settle("idle_restore", 0);
      chk("restore_code", 0, int'(LightScale), 80);
      chk("restore_dimmed", 0, int'(dimmed), 0);
      seen = 1'b0;
      for (int t = 0; t < 120; t++) begin
        @(negedge clk);
        if (dimmed) begin
          seen = 1'b1;
          break;
        end
      end
      chk("idle_dimmed2", 0, int'(seen), 1);
      push_ramp(8, 1);
      repeat (4) @(negedge clk);
      do_reset();
      chk("postreset_busy", 0, int'(busy), 0);
    end
`endif

    chk("legal_codes", 0, illegal_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1);
  end

endmodule
